// File: rtl/tk1_spi_master_if.sv
// Host-side handshake bundle for the tk1 SPI master.
// Carries chip-select request, byte start/ready handshake and data bytes.
interface tk1_spi_master_if;
    logic       spi_cs_en;
    logic       spi_start;
    logic [7:0] spi_tx_data;
    logic [7:0] spi_rx_data;
    logic       spi_ready;

    modport master (
        output spi_cs_en,
        output spi_start,
        output spi_tx_data,
        input  spi_rx_data,
        input  spi_ready
    );

    modport slave (
        input  spi_cs_en,
        input  spi_start,
        input  spi_tx_data,
        output spi_rx_data,
        output spi_ready
    );
endinterface

// File: rtl/tk1_spi_master.sv
// Byte-wide SPI mode-0 master for the tk1 flash port.
// MSB first; SCK half-period is SCLK_HALF system clocks.
module tk1_spi_master #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    tk1_spi_master_if.slave  host,
    input  logic             spi_miso,
    output logic             spi_mosi,
    output logic             spi_clk,
    output logic             spi_cs
);

    typedef enum logic [1:0] {
        IDLE,
        SCK_LOW,
        SCK_HIGH
    } state_t;

    localparam logic [3:0] DIV_LAST = 4'(SCLK_HALF - 1);

    state_t     state_q, state_d;
    logic [3:0] div_q,   div_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] tx_q,    tx_d;
    logic [7:0] rx_q,    rx_d;
    logic [7:0] rxd_q,   rxd_d;
    logic       sck_q,   sck_d;
    logic       cs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
            sck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
            sck_q   <= sck_d;
        end
    end

    // Chip select is firmware-owned and never gated by the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_q <= 1'b1;
        end else begin
            cs_q <= !host.spi_cs_en;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        sck_d   = sck_q;
        unique case (state_q)
            IDLE: begin
                if (host.spi_start) begin
                    tx_d    = host.spi_tx_data;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SCK_LOW;
                end
            end
            SCK_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], spi_miso};
                    state_d = SCK_HIGH;
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            SCK_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sck_d   = 1'b0;
                    tx_d    = {tx_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    state_d = SCK_LOW;
                    // Last bit already captured on the rising edge.
                    if (bit_q == 3'd7) begin
                        rxd_d   = rx_q;
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign host.spi_ready   = (state_q == IDLE);
    assign host.spi_rx_data = rxd_q;
    assign spi_mosi         = tx_q[7];
    assign spi_clk          = sck_q;
    assign spi_cs           = cs_q;

endmodule

// File: doc/tk1_spi_master.md
TK1_SPI_MASTER -- requirements
Module: tk1_spi_master

Interface
REQ-001 SHALL have parameter SCLK_HALF, default 2, meaning system clock cycles per SCK half-period (legal 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port spi_cs_en  input  1  chip-select request from the tk1 SPI_CTRL CS bit; 1 selects the device.
REQ-005 SHALL have port spi_start  input  1  single-cycle transfer request.
REQ-006 SHALL have port spi_tx_data  input  8  byte to transmit, sampled only in the accepting cycle.
REQ-007 SHALL have port spi_rx_data  output  8  last received byte.
REQ-008 SHALL have port spi_ready  output  1  1 = idle and able to accept spi_start.
REQ-009 SHALL have port spi_miso  input  1  serial data from the flash.
REQ-010 SHALL have port spi_mosi  output  1  serial data to the flash, MSB first.
REQ-011 SHALL have port spi_clk  output  1  SCK, mode 0 (idle low).
REQ-012 SHALL have port spi_cs  output  1  chip select, active-low.

Function
REQ-013 SHALL implement FSM states IDLE, SCK_LOW and SCK_HIGH; a divider counter, 0..SCLK_HALF-1; a 3-bit bit counter; an 8-bit TX shift register; and an 8-bit RX shift register.
REQ-014 SHALL, in IDLE with spi_start=1, load TX shift register <= spi_tx_data, clear bit counter and divider, drop spi_ready and enter SCK_LOW, all on the same edge.
REQ-015 SHALL ignore spi_start when spi_ready=0, with no effect on any state.
REQ-016 SHALL drive spi_mosi = TX shift register bit 7 continuously, so spi_mosi shows tx[7] from the cycle after acceptance.
REQ-017 SHALL hold SCK_LOW for SCLK_HALF cycles with spi_clk=0, then enter SCK_HIGH with spi_clk=1 and shift spi_miso into RX shift register bit 0 (left shift) on that same edge.
REQ-018 SHALL hold SCK_HIGH for SCLK_HALF cycles, then set spi_clk=0, shift the TX register left inserting 0, and increment the bit counter.
REQ-019 SHALL, at the SCK_HIGH exit with bit counter=7, copy the RX shift register to spi_rx_data, set spi_ready=1 and enter IDLE.
REQ-020 SHALL return spi_ready high exactly 16*SCLK_HALF cycles after the accepting edge, with spi_rx_data valid in that same cycle.
REQ-021 SHALL hold spi_rx_data stable from completion until the next completion; during a transfer it keeps the previous byte.
REQ-022 SHALL accept a new spi_start in the first cycle spi_ready=1, giving back-to-back bytes with a minimum SCK gap of SCLK_HALF low cycles.
REQ-023 SHALL register spi_cs <= !spi_cs_en every cycle, independent of FSM state; a change of spi_cs_en mid-transfer does not abort or stall the transfer.
REQ-024 SHALL run a transfer regardless of spi_cs_en; chip-select sequencing is firmware-owned.
REQ-025 SHALL have spi_mosi=0 in IDLE after any completed transfer, because the TX register has shifted fully out.

Reset
REQ-026 SHALL, while reset_n=0 and independent of clk, force state=IDLE, spi_clk=0, spi_cs=1, TX and RX shift registers = 0x00, spi_mosi=0, spi_rx_data=0x00, spi_ready=1, and all counters = 0.
REQ-027 SHALL, on reset assertion mid-transfer, abandon the transfer with no partial spi_rx_data update and no further SCK edges.
REQ-028 SHALL accept spi_start on the first rising clk edge after reset_n deasserts.

Verification
REQ-029 Reset check: assert reset_n=0 at an arbitrary point, no clk edge -> spi_clk=0, spi_cs=1, spi_mosi=0, spi_ready=1, spi_rx_data=0x00.
REQ-030 Loopback (SCLK_HALF=2): spi_miso tied to spi_mosi, start with tx 0xA5 -> spi_mosi bits 1,0,1,0,0,1,0,1; 8 SCK pulses of 2 high/2 low cycles; spi_ready returns at cycle 32; spi_rx_data=0xA5.
REQ-031 spi_miso held 1, tx 0x00 -> spi_mosi=0 throughout; spi_rx_data=0xFF; spi_cs follows !spi_cs_en with one-cycle latency.
REQ-032 Busy start: spi_start with tx 0x3C at cycle 5 of a 0x81 transfer -> ignored; MOSI stream and spi_rx_data match the 0x81 transfer only.
REQ-033 Reset during bit 3 of a transfer -> immediate reset values, previous spi_rx_data cleared to 0x00; a following 0x5A loopback transfer returns 0x5A.
REQ-034 Back-to-back: spi_start in the completion cycle with tx 0x12 -> accepted; second byte completes exactly 32 cycles later with spi_rx_data=0x12 in loopback.
